// File: rtl/pool_pkg.sv
// Shared types and default sizing for the pooling result collector.
//   LANE_W        lane index width used in the output address
//   pool_entry_t  one buffered lane result {last, addr, data}
//   coll_state_t  collector FSM states
package pool_pkg;
  localparam int POOL_NUM      = 16;
  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 10;
  localparam int FIFO_DEPTH    = 4;
  localparam int LANE_W        = $clog2(POOL_NUM);

  typedef struct packed {
    logic                     last;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } pool_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} coll_state_t;
endpackage

// File: rtl/pool_result_collector_if.sv
// Bus between the pooling array / output SRAM side and the collector.
//   pool_*       per-lane result streams (no backpressure)
//   mem_*        single output-buffer write port, held until mem_ready_i
//   start_i      layer start pulse; done_o/overflow_o/busy_o status
// slave = collector side, master = the surrounding system.
interface pool_result_collector_if #(
  parameter int POOL_NUM      = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int LANE_W        = $clog2(POOL_NUM)
);
  logic                                        start_i;
  logic [POOL_NUM-1:0]                         pool_valid_i;
  logic [POOL_NUM-1:0]                         pool_last_i;
  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]         pool_result_i;
  logic [POOL_NUM-1:0][ADDRESS_WIDTH-1:0]      pool_result_address_i;
  logic                                        mem_we_o;
  logic [LANE_W+ADDRESS_WIDTH-1:0]             mem_addr_o;
  logic [DATA_WIDTH-1:0]                       mem_wdata_o;
  logic                                        mem_ready_i;
  logic                                        done_o;
  logic                                        overflow_o;
  logic                                        busy_o;

  modport slave (
    input  start_i, pool_valid_i, pool_last_i, pool_result_i, pool_result_address_i, mem_ready_i,
    output mem_we_o, mem_addr_o, mem_wdata_o, done_o, overflow_o, busy_o
  );
  modport master (
    output start_i, pool_valid_i, pool_last_i, pool_result_i, pool_result_address_i, mem_ready_i,
    input  mem_we_o, mem_addr_o, mem_wdata_o, done_o, overflow_o, busy_o
  );
endinterface

// File: rtl/pool_result_collector_fifo.sv
// pool_lane_fifo: small synchronous FIFO for one pooling lane.
//   push_i/din_i  write side; a push into a full FIFO is accepted only if
//                 a pop happens on the same edge, otherwise it is dropped
//   pop_i/dout_o  read side; dout_o shows the head entry (first-word fall-through)
//   full_o/empty_o occupancy flags
module pool_lane_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pool_result_collector.sv
// pool_result_collector: buffers the per-lane pooling results, merges them
// round-robin onto one output-buffer write port and tracks layer completion.
//   clk, rst  clock, asynchronous active-high reset
//   bus       pool_result_collector_if.slave (lane streams, mem write port, status)
// Entry widths come from pool_pkg; the width parameters here must match it.
module pool_result_collector #(
  parameter int POOL_NUM      = pool_pkg::POOL_NUM,
  parameter int DATA_WIDTH    = pool_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = pool_pkg::ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = pool_pkg::FIFO_DEPTH
) (
  input logic                    clk,
  input logic                    rst,
  pool_result_collector_if.slave bus
);
  import pool_pkg::*;

  localparam int LW = $clog2(POOL_NUM);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  pool_entry_t [POOL_NUM-1:0] head;
  logic [POOL_NUM-1:0] f_full, f_empty, f_pop;
  logic [POOL_NUM-1:0] lane_done;
  logic [LW-1:0]       rr_ptr, gnt_idx, gnt_next;
  logic                gnt_vld, load, accept, drop;
  logic                we_q, last_q, ovf_q;
  logic [LW+ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]          state;

  for (genvar l = 0; l < POOL_NUM; l++) begin : g_lane
    pool_entry_t din;
    assign din = '{last: bus.pool_last_i[l],
                   addr: bus.pool_result_address_i[l],
                   data: bus.pool_result_i[l]};
    pool_lane_fifo #(.W($bits(pool_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (bus.pool_valid_i[l]),
      .din_i  (din),
      .pop_i  (f_pop[l]),
      .dout_o (head[l]),
      .full_o (f_full[l]),
      .empty_o(f_empty[l])
    );
  end

  // Scan downward over offsets so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = POOL_NUM - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr) + i) % POOL_NUM;
      if (!f_empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'(idx);
      end
    end
  end

  assign gnt_next = (gnt_idx == LW'(POOL_NUM - 1)) ? '0 : gnt_idx + 1'b1;
  // Register may take a new entry when empty or its entry is leaving now.
  assign load     = !we_q || bus.mem_ready_i;
  assign accept   = we_q && bus.mem_ready_i;

  always_comb begin
    f_pop = '0;
    if (load && gnt_vld) f_pop[gnt_idx] = 1'b1;
  end

  // A full FIFO that is popped this edge still takes the push.
  assign drop = |(bus.pool_valid_i & f_full & ~f_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      we_q <= gnt_vld;
      if (gnt_vld) begin
        addr_q  <= {gnt_idx, head[gnt_idx].addr};
        wdata_q <= head[gnt_idx].data;
        last_q  <= head[gnt_idx].last;
        rr_ptr  <= gnt_next;
      end
    end
  end

  // start_i has priority over a coinciding last-acceptance or drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_done <= '0;
      ovf_q     <= 1'b0;
    end else if (bus.start_i) begin
      lane_done <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept && last_q) lane_done[addr_q[LW+ADDRESS_WIDTH-1:ADDRESS_WIDTH]] <= 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start_i) state <= ST_RUN;
        ST_RUN:  if (!bus.start_i && &lane_done && !we_q) state <= ST_DONE;
        ST_DONE: if (bus.start_i) state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.done_o      = (state == ST_DONE);
  assign bus.busy_o      = (state == ST_RUN);
endmodule

// File: tb/tb_pool_result_collector.sv
module tb_pool_result_collector;
  localparam int NL = 16;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_result_collector_if #(.POOL_NUM(NL), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LANE_W(LW)) pif ();

  pool_result_collector #(.POOL_NUM(NL), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(pif)
  );

  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_q [NL][$];
  int ord_q[$];
  bit ord_en = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sb_count();
    int n = 0;
    for (int i = 0; i < NL; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Write monitor: per-lane scoreboard, optional grant order, hold stability.
  logic          stall_prev = 1'b0;
  logic [LW+AW-1:0] addr_prev;
  logic [DW-1:0] data_prev;
  always @(negedge clk) begin
    int lane;
    logic [AW+DW-1:0] e;
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_we", pif.mem_we_o, 1);
        chk("hold_addr", pif.mem_addr_o, addr_prev);
        chk("hold_data", pif.mem_wdata_o, data_prev);
      end
      if (pif.mem_we_o && pif.mem_ready_i) begin
        lane = int'(pif.mem_addr_o[LW+AW-1:AW]);
        chk("sb_has_entry", exp_q[lane].size() > 0, 1);
        if (exp_q[lane].size() > 0) begin
          e = exp_q[lane].pop_front();
          chk("wr_addr", pif.mem_addr_o[AW-1:0], e[AW+DW-1:DW]);
          chk("wr_data", pif.mem_wdata_o, e[DW-1:0]);
        end
        if (ord_en && ord_q.size() > 0) chk("rr_order", lane, ord_q.pop_front());
      end
      stall_prev <= pif.mem_we_o && !pif.mem_ready_i;
      addr_prev  <= pif.mem_addr_o;
      data_prev  <= pif.mem_wdata_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pif.pool_valid_i = '0;
    pif.pool_last_i  = '0;
    pif.start_i      = 1'b0;
  endtask

  task automatic push(int l, bit last, logic [AW-1:0] a, logic [DW-1:0] d, bit keep);
    pif.pool_valid_i[l]          = 1'b1;
    pif.pool_last_i[l]           = last;
    pif.pool_result_i[l]         = d;
    pif.pool_result_address_i[l] = a;
    if (keep) exp_q[l].push_back({a, d});
  endtask

  task automatic drain(string tag);
    int n = 0;
    while ((sb_count() > 0 || pif.mem_we_o) && n < 200) begin
      step();
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    while (!pif.done_o && n < budget) begin
      step();
      n++;
    end
    chk(tag, pif.done_o, 1);
  endtask

  initial begin
    pif.start_i = 1'b0;
    pif.pool_valid_i = '0;
    pif.pool_last_i = '0;
    pif.pool_result_i = '0;
    pif.pool_result_address_i = '0;
    pif.mem_ready_i = 1'b1;

    // Reset state
    #12;
    chk("rst_we", pif.mem_we_o, 0);
    chk("rst_done", pif.done_o, 0);
    chk("rst_ovf", pif.overflow_o, 0);
    chk("rst_busy", pif.busy_o, 0);
    #10 rst = 1'b0;
    step();

    // Round-robin from pointer 0
    ord_en = 1'b1;
    ord_q = '{0, 5, 15, 0, 5, 15};
    push(0, 0, 10'h000, 8'h01, 1); push(5, 0, 10'h050, 8'h51, 1); push(15, 0, 10'h0F0, 8'hF1, 1);
    step();
    push(0, 0, 10'h001, 8'h02, 1); push(5, 0, 10'h051, 8'h52, 1); push(15, 0, 10'h0F1, 8'hF2, 1);
    step();
    drain("rr_drain");
    chk("rr_all_seen", ord_q.size(), 0);
    ord_en = 1'b0;

    // Single-lane flow
    pif.start_i = 1'b1;
    step();
    chk("start_busy", pif.busy_o, 1);
    for (int k = 0; k < 4; k++) begin
      push(3, k == 3, AW'(k), DW'(8'h11 + k), 1);
      if (k == 0)
        for (int l = 0; l < NL; l++)
          if (l != 3) push(l, 1, 10'h3FF, DW'(8'hA0 + l), 1);
      step();
    end
    wait_done("single_done", 100);
    chk("single_sb_empty", sb_count(), 0);
    chk("single_busy", pif.busy_o, 0);
    chk("single_ovf", pif.overflow_o, 0);

    // Backpressure: one entry held in the register, FIFO fills, 6th push drops
    pif.mem_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push(2, 0, AW'(10'h100 + k), DW'(8'h20 + k), k < 5);
      step();
      if (k == 4) chk("bp_ovf_before", pif.overflow_o, 0);
      if (k == 5) chk("bp_ovf_after", pif.overflow_o, 1);
    end
    step(); step();
    chk("bp_done_kept", pif.done_o, 1);
    pif.mem_ready_i = 1'b1;
    drain("bp_drain");

    // Restart from DONE
    pif.start_i = 1'b1;
    step();
    chk("restart_done", pif.done_o, 0);
    chk("restart_ovf", pif.overflow_o, 0);
    chk("restart_busy", pif.busy_o, 1);

    // start_i collides with lane 7 last acceptance
    pif.mem_ready_i = 1'b0;
    push(7, 1, 10'h077, 8'h77, 1);
    step(); step(); step();
    chk("coll_held", pif.mem_we_o, 1);
    pif.mem_ready_i = 1'b1;
    pif.start_i = 1'b1;
    step();
    for (int l = 0; l < NL; l++)
      if (l != 7) push(l, 1, 10'h3FF, DW'(8'hB0 + l), 1);
    step();
    drain("coll_drain");
    step(); step(); step();
    chk("coll_lane7_not_done", pif.done_o, 0);
    chk("coll_still_busy", pif.busy_o, 1);
    push(7, 1, 10'h078, 8'h78, 1);
    step();
    wait_done("coll_done", 50);

    // Full FIFO popped in the same cycle as a push
    pif.mem_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(4, 0, AW'(10'h040 + k), DW'(8'h40 + k), 1);
      step();
    end
    chk("fp_ovf_full", pif.overflow_o, 0);
    pif.mem_ready_i = 1'b1;
    push(4, 0, 10'h045, 8'h45, 1);
    step();
    chk("fp_no_ovf", pif.overflow_o, 0);
    drain("fp_drain");
    chk("fp_ovf_end", pif.overflow_o, 0);

    // Asynchronous reset mid-stream
    pif.mem_ready_i = 1'b0;
    push(9, 0, 10'h099, 8'h99, 1);
    push(10, 0, 10'h0AA, 8'hAA, 1);
    step(); step(); step();
    chk("pre_rst_we", pif.mem_we_o, 1);
    chk("pre_rst_done", pif.done_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", pif.mem_we_o, 0);
    chk("arst_done", pif.done_o, 0);
    chk("arst_busy", pif.busy_o, 0);
    for (int i = 0; i < NL; i++) exp_q[i].delete();
    @(posedge clk);
    #3 rst = 1'b0;
    pif.mem_ready_i = 1'b1;
    step(); step(); step(); step();
    chk("post_rst_empty", pif.mem_we_o, 0);
    push(1, 0, 10'h011, 8'h5A, 1);
    step();
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
